mio_arbiter: RTL and testbench

Two-master arbiter and wait-state sequencer for the shared memory/IO (MIO) bus of the multicycle CPU system. Port 0 is driven by the multicycle controller (CPU_MIO / MemRead / MemWrite path); port 1 serves a secondary bus master such as a DMA or display fetch engine. The block grants one master at a time and drives the single memory port. It counts a fixed number of memory wait states and returns read data with a ready handshake. Its cpu_ready output is the MIO_ready input of the controller.

---
 rtl/mio_arbiter.sv | 116 +++++++++++
 tb/tb_mio_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mio_arbiter.sv
// Two-master MIO bus arbiter with a fixed wait-state access sequencer.
// Define MIO_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
//
// state    | meaning
// S_IDLE   | arbitrate, latch winner's request, load wait counter
// S_ACCESS | memory strobed, counting wait states, capture read data at zero
// S_RESP   | owner's ready asserted for one cycle, then release grant

module mio_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       mem_we_q;
  logic       any_req;
  logic       pick_dev;

  assign any_req = cpu_req | dev_req;

`ifdef MIO_ARB_RR_EN
  // last_grant = 1 means the secondary master was served last
  logic last_grant;

  assign pick_dev = dev_req & (~cpu_req | ~last_grant);

  always_ff @(posedge clk) begin
    if (!reset)
      last_grant <= 1'b1;
    else if (state == S_IDLE && any_req)
      last_grant <= pick_dev;
  end
`else
  assign pick_dev = dev_req & ~cpu_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      grant     <= 2'b00;
      mem_we_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dev_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state     <= S_ACCESS;
            cnt       <= 4'(WAIT_CYCLES);
            grant     <= pick_dev ? 2'b10 : 2'b01;
            mem_we_q  <= pick_dev ? dev_we : cpu_we;
            mem_addr  <= pick_dev ? dev_addr : cpu_addr;
            mem_wdata <= pick_dev ? dev_wdata : cpu_wdata;
          end
        end
        S_ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!mem_we_q) begin
              if (grant[1]) dev_rdata <= mem_rdata;
              else          cpu_rdata <= mem_rdata;
            end
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          grant <= 2'b00;
        end
        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign mem_en = (state == S_ACCESS);
  assign mem_we = mem_en & mem_we_q;

  // cpu_ready idles high so the controller's non-memory states never stall
  assign cpu_ready = reset & (~cpu_req | ((state == S_RESP) & grant[0]));
  assign dev_ready = reset & (state == S_RESP) & grant[1];

endmodule

// File: tb/tb_mio_arbiter.sv
// Randomized self-checking bench for mio_arbiter against a transaction-timing model.
// Honours MIO_ARB_RR_EN to select the expected arbitration policy.

module tb_mio_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dev_req, dev_we;
  logic [AW-1:0] cpu_addr, dev_addr;
  logic [DW-1:0] cpu_wdata, dev_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dev_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          cpu_ready, dev_ready, mem_en, mem_we;
  logic [1:0]    grant;

  int checks = 0;
  int failures = 0;

  // model: busy = cycles since the accepting edge (0 = idle), W+2 = response cycle
  int            busy;
  logic          owner_dev, we_l, last_dev;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] wdata_l, m_crd, m_drd;
  logic          saw_c, saw_d;

  always #5 clk = ~clk;

  mio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ready(dev_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    logic pick;
    if (!reset) begin
      busy = 0; owner_dev = 0; we_l = 0; addr_l = '0; wdata_l = '0;
      m_crd = '0; m_drd = '0; last_dev = 1'b1;
    end else if (busy == 0) begin
      if (cpu_req || dev_req) begin
`ifdef MIO_ARB_RR_EN
        pick = dev_req && (!cpu_req || !last_dev);
`else
        pick = dev_req && !cpu_req;
`endif
        owner_dev = pick;
        last_dev  = pick;
        we_l    = pick ? dev_we : cpu_we;
        addr_l  = pick ? dev_addr : cpu_addr;
        wdata_l = pick ? dev_wdata : cpu_wdata;
        busy = 1;
      end
    end else if (busy == W + 2) begin
      busy = 0;
    end else begin
      if (busy == W + 1 && !we_l) begin
        if (owner_dev) m_drd = mem_rdata;
        else           m_crd = mem_rdata;
      end
      busy++;
    end
  endtask

  task automatic check_outputs();
    logic en_e;
    en_e = (busy >= 1) && (busy <= W + 1);
    check("mem_en", mem_en, en_e);
    check("mem_we", mem_we, en_e && we_l);
    check("grant", grant, (busy == 0) ? 2'b00 : (owner_dev ? 2'b10 : 2'b01));
    check("cpu_ready", cpu_ready, reset && (!cpu_req || (busy == W + 2 && !owner_dev)));
    check("dev_ready", dev_ready, reset && busy == W + 2 && owner_dev);
    check("mem_addr", mem_addr, addr_l);
    check("mem_wdata", mem_wdata, wdata_l);
    check("cpu_rdata", cpu_rdata, m_crd);
    check("dev_rdata", dev_rdata, m_drd);
  endtask

  // one bus cycle: check mid-cycle, advance the model at the edge, then requesters react
  task automatic cyc();
    @(negedge clk);
    check_outputs();
    saw_c = cpu_ready;
    saw_d = dev_ready;
    @(posedge clk);
    model_edge();
    #1;
    if (saw_c && cpu_req) cpu_req = 1'b0;
    if (saw_d && dev_req) dev_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dev_req = 0; dev_we = 0; dev_addr = '0; dev_wdata = '0;
    mem_rdata = '0;
    @(posedge clk);
    model_edge();
    #1;
    cyc();
    reset = 1'b1;
    repeat (3) cyc();

    // CPU read at 0x10
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    repeat (7) cyc();
    check("dir_cpu_rdata", cpu_rdata, 64'hDEADBEEF);

    // secondary-master write
    dev_req = 1; dev_we = 1; dev_addr = 32'h200; dev_wdata = 32'h1234;
    repeat (7) cyc();
    check("dir_dev_rdata", dev_rdata, 64'h0);

    // simultaneous requests, twice
    for (int k = 0; k < 2; k++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40 + k; mem_rdata = 32'hA5A50000 + k;
      dev_req = 1; dev_we = 0; dev_addr = 32'h80 + k;
      repeat (12) cyc();
    end

    // reset during the second ACCESS cycle of a CPU read
    repeat (2) cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; mem_rdata = 32'h55AA55AA;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cpu_req = 1'b0;
    cyc();
    check("dir_rst_cpu_rdata", cpu_rdata, 64'h0);
    check("dir_rst_grant", grant, 64'h0);

    // randomized traffic with occasional resets and owner-side input churn
    for (int i = 0; i < 1500; i++) begin
      mem_rdata = $urandom;
      reset = ($urandom_range(0, 99) != 0);
      if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1; cpu_we = $urandom_range(0, 1); cpu_addr = $urandom; cpu_wdata = $urandom;
      end else if (cpu_req && $urandom_range(0, 7) == 0) begin
        cpu_we = $urandom_range(0, 1); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (!dev_req && $urandom_range(0, 3) == 0) begin
        dev_req = 1; dev_we = $urandom_range(0, 1); dev_addr = $urandom; dev_wdata = $urandom;
      end else if (dev_req && $urandom_range(0, 7) == 0) begin
        dev_we = $urandom_range(0, 1); dev_addr = $urandom; dev_wdata = $urandom;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
